// File: rtl/fixed_div_pkg.sv
// fixed_div_pkg: shared types and constants for the fixed-point divider
package fixed_div_pkg;
  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;
  typedef enum logic [1:0] {IDLE, DIV, FIN} state_e;
endpackage

// File: rtl/fixed_div_unit.sv
// fixed_div_unit: multicycle signed 8.8 by unsigned integer restoring divider, truncating toward zero
module fixed_div_unit
  import fixed_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [DW-1:0] Dividend,
  input  logic [VW-1:0] Divisor,
  output logic          Busy,
  output logic          Done,
  output logic [DW-1:0] Quotient,
  output logic          DivByZero
);
  localparam int CW = $clog2(DW);
  state_e state_q, state_d;
  logic [DW-1:0] mag_q, mag_d, quo_q, quo_d, res_q, res_d;
  logic [VW-1:0] div_q, div_d, rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sign_q, sign_d, zdiv_q, zdiv_d, dbz_q, dbz_d, done_q, done_d;
  logic [VW:0] rem_sh;
  logic ge;
  assign Busy = state_q != IDLE;
  assign Done = done_q;
  assign Quotient = res_q;
  assign DivByZero = dbz_q;
  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      zdiv_q  <= zdiv_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end
  // Next state: accept in IDLE, one restoring step per DIV cycle, sign-fix and publish in FIN
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    quo_d   = quo_q;
    res_d   = res_q;
    div_d   = div_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    zdiv_d  = zdiv_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    rem_sh  = {rem_q, mag_q[DW-1]};
    ge      = rem_sh >= {1'b0, div_q};
    case (state_q)
      IDLE: if (Start) begin
        sign_d  = Dividend[DW-1];
        mag_d   = Dividend[DW-1] ? -Dividend : Dividend;
        div_d   = Divisor;
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
        zdiv_d  = Divisor == '0;
        state_d = Divisor == '0 ? FIN : DIV;
      end
      DIV: begin
        rem_d   = VW'(ge ? rem_sh - {1'b0, div_q} : rem_sh);
        quo_d   = {quo_q[DW-2:0], ge};
        mag_d   = mag_q << 1;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(DW - 1) ? FIN : DIV;
      end
      FIN: begin
        res_d   = zdiv_q ? (sign_q ? SAT_NEG : SAT_POS) : (sign_q ? -quo_q : quo_q);
        dbz_d   = zdiv_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fixed_div_unit.sv
// tb_fixed_div_unit: scoreboard bench for the fixed-point divider against an integer-division model
module tb_fixed_div_unit;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] Dividend = '0;
  logic [7:0]  Divisor = '0;
  logic        Busy, Done, DivByZero;
  logic [15:0] Quotient;

  typedef struct {
    logic [15:0] q;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] last_q = '0;
  logic        last_dz = 1'b0;

  fixed_div_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
    .Busy(Busy), .Done(Done), .Quotient(Quotient), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [7:0] b);
    int n;
    if (b == 8'd0) return a[15] ? 16'h8000 : 16'h7FFF;
    n = int'($signed(a)) / int'(b);
    return n[15:0];
  endfunction

  task automatic push(input logic [15:0] a, input logic [7:0] b);
    sb.push_back('{q: ref_q(a, b), dz: (b == 8'd0), due: cyc + ((b == 8'd0) ? 2 : 18)});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk("completion_timeout", n < 100, 1);
    @(negedge Clk);
    chk("held_quotient", Quotient, last_q);
    chk("held_divbyzero", DivByZero, last_dz);
  endtask

  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    @(negedge Clk);
    Dividend = a;
    Divisor = b;
    Start = 1'b1;
    push(a, b);
    @(negedge Clk);
    Start = 1'b0;
    chk("busy_after_accept", Busy, 1);
    Dividend = 16'($urandom);
    Divisor = 8'($urandom);
    wait_idle();
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      if (Done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done got=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", Quotient, e.q);
          chk("divbyzero", DivByZero, e.dz);
          chk("done_cycle", cyc, e.due);
          chk("busy_at_done", Busy, 0);
          last_q = e.q;
          last_dz = e.dz;
        end
      end else if (sb.size() != 0 && cyc >= sb[0].due) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_done got=0 expected=1 (cycle %0d, quotient %0h)", cyc, e.q);
      end
    end
  end

  logic [15:0] dir_a [12] = '{16'h0600, 16'h3900, 16'h1100, 16'hF700, 16'hFFFF, 16'h8000,
                              16'h0100, 16'hFF00, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
  logic [7:0]  dir_b [12] = '{8'd3, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1,
                              8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd1};

  initial begin
    #3 Reset = 1'b0;
    #4;
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_quotient", Quotient, 16'h0000);
    chk("reset_divbyzero", DivByZero, 0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 12; i++) issue(dir_a[i], dir_b[i]);
    for (int i = 0; i < 40; i++) issue(16'($urandom), ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
    @(negedge Clk);
    Dividend = 16'hE480;
    Divisor = 8'd7;
    Start = 1'b1;
    push(16'hE480, 8'd7);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      Start = 1'($urandom);
      Dividend = 16'($urandom);
      Divisor = 8'($urandom);
    end
    Start = 1'b0;
    wait_idle();
    repeat (20) @(negedge Clk);
    @(negedge Clk);
    Dividend = 16'h0600;
    Divisor = 8'd3;
    Start = 1'b1;
    push(16'h0600, 8'd3);
    repeat (18) @(negedge Clk);
    Dividend = 16'hF700;
    Divisor = 8'd2;
    push(16'hF700, 8'd2);
    @(negedge Clk);
    Start = 1'b0;
    chk("b2b_busy", Busy, 1);
    wait_idle();
    repeat (20) @(negedge Clk);
    @(negedge Clk);
    Dividend = 16'h1234;
    Divisor = 8'd7;
    Start = 1'b1;
    push(16'h1234, 8'd7);
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(negedge Clk);
    #2 Reset = 1'b0;
    sb.delete();
    last_q = '0;
    last_dz = 1'b0;
    #1;
    chk("midop_reset_busy", Busy, 0);
    chk("midop_reset_done", Done, 0);
    chk("midop_reset_quotient", Quotient, 16'h0000);
    chk("midop_reset_divbyzero", DivByZero, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (25) @(negedge Clk);
    chk("post_reset_quotient", Quotient, 16'h0000);
    issue(16'h0900, 8'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
